pcler8_seq_ctrl: RTL and testbench
==================================

Name: pcler8_seq_ctrl

Overview:
Sequencer and shared-access arbiter for the 8-bit parallel-load counter datapath (pcler8 class).
- Holds the counter state register.
- Arbitrates load requests from two requesters.
- Paces counting with a programmable prescaler.
- Detects terminal count, then either reloads or stops.
- Sits between the requesters and the combinational counter next-state logic.

Parameters:
WIDTH, 8, counter and load-data width
PRESC_W, 4, prescaler compare width

Ports:
clk_pad  input  1  clock; all state updates on rising edge
rst_n_pad  input  1  reset; synchronous, active-low
req0_pad  input  1  load request, requester 0; held until gnt0_pad seen
req1_pad  input  1  load request, requester 1; held until gnt1_pad seen
data0_pad  input  WIDTH  load value, requester 0
data1_pad  input  WIDTH  load value, requester 1
gnt0_pad  output  1  one-cycle registered grant, requester 0
gnt1_pad  output  1  one-cycle registered grant, requester 1
start_pad  input  1  begin or restart counting
stop_pad  input  1  abort to IDLE
auto_pad  input  1  1 = auto-reload at terminal count; 0 = one-shot
presc_pad  input  PRESC_W  one count tick every presc_pad+1 cycles
count_pad  output  WIDTH  current counter value
tc_pad  output  1  one-cycle registered terminal-count pulse
busy_pad  output  1  high while state is RUN
state_pad  output  2  IDLE=0, ARMED=1, RUN=2, DONE=3

Behaviour:
Reset (rst_n_pad=0 at clock edge):
- state IDLE; count, reload and prescaler = 0.
- gnt0/gnt1/tc/busy = 0.
- Round-robin pointer favours req0.
- Reset overrides every other input and applies mid-count.

Arbitration:
- Requests are accepted only in IDLE or DONE, and only when no grant was issued in the previous cycle. The cycle after a grant is blocked so the requester can drop req.
- One request active: it wins. Both active: the requester pointed to wins, and the pointer then moves to the other requester.
- On the accept edge:
  - reload <= winner data
  - count <= winner data
  - gnt of the winner <= 1 for exactly one cycle
  - state -> ARMED
- Requests in ARMED or RUN are ignored; no grant is issued.

FSM:
- IDLE: start_pad is ignored; only accepts loads.
- ARMED:
  - stop_pad -> IDLE.
  - else start_pad -> RUN, prescaler cleared to 0.
- RUN:
  - stop_pad -> IDLE; count holds its current value.
  - else prescaler increments each cycle. A tick occurs when prescaler == presc_pad; the prescaler then returns to 0.
  - On tick with count != all-ones: count <= count+1, wrapping modulo 2^WIDTH.
  - On tick with count == all-ones: tc_pad = 1 in the following cycle.
    - auto_pad=1: count <= reload, stay in RUN.
    - auto_pad=0: count holds all-ones, state -> DONE.
- DONE:
  - A winning request takes priority: load as above, -> ARMED.
  - else start_pad: count <= reload, prescaler <= 0, -> RUN.
  - stop_pad -> IDLE.

Simultaneous events and boundaries:
- stop beats start in every state.
- In DONE: a request beats start, and start beats stop only when no stop is present.
- presc_pad=0: tick every cycle.
- presc_pad is sampled live; a change mid-period compares against the new value.
- Loading all-ones and starting with presc 0: tc pulses the cycle after the first RUN cycle.
- auto_pad is sampled at the terminal tick only.

Latency:
- gnt, tc, count and state are registered; each updates one edge after its causing input.

Outputs:
- busy_pad = (state == RUN), registered together with state.

Test Plan:
1. Reset: assert rst_n_pad=0 for 2 cycles with req0=1, start=1 -> state 0, count 0, no grant, tc 0.
2. Single load + one-shot: req0, data0=8'hFC, then start, presc=0, auto=0 -> gnt0 pulse 1 cycle; counts FD, FE, FF; tc pulses once; state DONE; count holds FF.
3. Round-robin: req0 and req1 both held, data0=10, data1=20, with a stop after each grant -> grants go req0 (count 10), then req1 (count 20), then req0. There is no back-to-back grant in adjacent cycles.
4. Prescaler + auto-reload: load 8'hFE, presc=3, auto=1, start -> count advances every 4 cycles; FF -> tc -> FE; tc every 8 cycles thereafter; busy stays 1.
5. Stop/start priority: in RUN, assert start=1 and stop=1 together -> IDLE, count frozen, busy 0. Then in DONE, assert req1, start and stop together -> load accepted, gnt1, ARMED.
6. Reset mid-count: reset at count 8'h80 in RUN -> next cycle state IDLE, count 0, tc 0, pointer back to req0.

Source files
------------

// File: rtl/pcler8_seq_ctrl.sv
// Sequencer and two-requester load arbiter for the pcler8 parallel-load counter.
// Owns the counter, reload and prescaler registers; all outputs are registered.
module pcler8_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk_pad,
    input  logic               rst_n_pad,
    input  logic               req0_pad,
    input  logic               req1_pad,
    input  logic [WIDTH-1:0]   data0_pad,
    input  logic [WIDTH-1:0]   data1_pad,
    output logic               gnt0_pad,
    output logic               gnt1_pad,
    input  logic               start_pad,
    input  logic               stop_pad,
    input  logic               auto_pad,
    input  logic [PRESC_W-1:0] presc_pad,
    output logic [WIDTH-1:0]   count_pad,
    output logic               tc_pad,
    output logic               busy_pad,
    output logic [1:0]         state_pad
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               rr_q, rr_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               tc_q, tc_d;
    logic               busy_q, busy_d;

    logic               load_ok;
    logic               win1;
    logic [WIDTH-1:0]   win_data;
    logic               tick;

    // Winner selection; the round-robin pointer only matters when both contend.
    always_comb begin
        win1     = (req0_pad && req1_pad) ? rr_q : req1_pad;
        win_data = win1 ? data1_pad : data0_pad;
        load_ok  = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                   && !gnt0_q && !gnt1_q && (req0_pad || req1_pad);
        tick     = (presc_q == presc_pad);
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        rr_d     = rr_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        tc_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only loads leave IDLE; handled below.
            end
            ST_ARMED: begin
                if (stop_pad) begin
                    state_d = ST_IDLE;
                end else if (start_pad) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (stop_pad) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (count_q != ALL_ONES) begin
                        count_d = count_q + WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
                        if (auto_pad) begin
                            count_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_DONE: begin
                if (stop_pad) begin
                    state_d = ST_IDLE;
                end else if (start_pad) begin
                    state_d = ST_RUN;
                    count_d = reload_q;
                    presc_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accepted load overrides stop/start in IDLE and DONE.
        if (load_ok) begin
            state_d  = ST_ARMED;
            count_d  = win_data;
            reload_d = win_data;
            gnt0_d   = !win1;
            gnt1_d   = win1;
            if (req0_pad && req1_pad) begin
                rr_d = !win1;
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_pad) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n_pad) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            rr_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            rr_q     <= rr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt0_pad  = gnt0_q;
    assign gnt1_pad  = gnt1_q;
    assign count_pad = count_q;
    assign tc_pad    = tc_q;
    assign busy_pad  = busy_q;
    assign state_pad = state_q;

endmodule

// File: tb/tb_pcler8_seq_ctrl.sv
// Directed bench for pcler8_seq_ctrl: each driven cycle pushes its expected
// outputs to a scoreboard; a monitor pops and compares just after the edge.
module tb_pcler8_seq_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk_pad = 1'b0;
    logic       rst_n_pad, req0_pad, req1_pad, start_pad, stop_pad, auto_pad;
    logic [7:0] data0_pad, data1_pad;
    logic [3:0] presc_pad;
    logic       gnt0_pad, gnt1_pad, tc_pad, busy_pad;
    logic [7:0] count_pad;
    logic [1:0] state_pad;

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;

    pcler8_seq_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk_pad   (clk_pad),
        .rst_n_pad (rst_n_pad),
        .req0_pad  (req0_pad),
        .req1_pad  (req1_pad),
        .data0_pad (data0_pad),
        .data1_pad (data1_pad),
        .gnt0_pad  (gnt0_pad),
        .gnt1_pad  (gnt1_pad),
        .start_pad (start_pad),
        .stop_pad  (stop_pad),
        .auto_pad  (auto_pad),
        .presc_pad (presc_pad),
        .count_pad (count_pad),
        .tc_pad    (tc_pad),
        .busy_pad  (busy_pad),
        .state_pad (state_pad)
    );

    always #5 clk_pad = ~clk_pad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {st,busy,g0,g1,tc,cnt}=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input string tag, input logic rst, input logic r0, input logic r1,
                       input logic st, input logic sp, input logic au, input logic [3:0] pr,
                       input logic [1:0] es, input logic eg0, input logic eg1,
                       input logic etc, input logic [7:0] ec);
        sb_entry_t e;
        rst_n_pad = rst;
        req0_pad  = r0;
        req1_pad  = r1;
        start_pad = st;
        stop_pad  = sp;
        auto_pad  = au;
        presc_pad = pr;
        e.tag = tag;
        e.exp = {es, (es == S_RUN), eg0, eg1, etc, ec};
        sb.push_back(e);
        @(negedge clk_pad);
    endtask

    always @(posedge clk_pad) begin
        #1;
        if (sb.size() != 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check(e.tag, 32'({state_pad, busy_pad, gnt0_pad, gnt1_pad, tc_pad, count_pad}),
                  32'(e.exp));
        end
    end

    initial begin
        data0_pad = 8'h00;
        data1_pad = 8'h00;

        // Reset dominates requests and start.
        repeat (2) cyc("t1_reset", 0, 1, 0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 8'h00);

        // Single load, one-shot count to terminal.
        data0_pad = 8'hFC;
        cyc("t2_load",    1, 1, 0, 0, 0, 0, 0, S_ARMED, 1, 0, 0, 8'hFC);
        cyc("t2_armed",   1, 0, 0, 0, 0, 0, 0, S_ARMED, 0, 0, 0, 8'hFC);
        cyc("t2_start",   1, 0, 0, 1, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFC);
        cyc("t2_fd",      1, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFD);
        cyc("t2_fe",      1, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFE);
        cyc("t2_ff",      1, 0, 0, 0, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFF);
        cyc("t2_tc",      1, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 1, 8'hFF);
        repeat (2) cyc("t2_hold", 1, 0, 0, 0, 0, 0, 0, S_DONE, 0, 0, 0, 8'hFF);

        // Round-robin with both requests held.
        cyc("t3_to_idle", 1, 0, 0, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'hFF);
        data0_pad = 8'd10;
        data1_pad = 8'd20;
        cyc("t3_g0",      1, 1, 1, 0, 0, 0, 0, S_ARMED, 1, 0, 0, 8'd10);
        cyc("t3_stop_a",  1, 1, 1, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'd10);
        cyc("t3_g1",      1, 1, 1, 0, 0, 0, 0, S_ARMED, 0, 1, 0, 8'd20);
        cyc("t3_stop_b",  1, 1, 1, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'd20);
        cyc("t3_g0_again",1, 1, 1, 0, 0, 0, 0, S_ARMED, 1, 0, 0, 8'd10);
        cyc("t3_stop_c",  1, 0, 0, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'd10);

        // Prescaler 3 with auto-reload.
        data0_pad = 8'hFE;
        cyc("t4_load",    1, 1, 0, 0, 0, 1, 3, S_ARMED, 1, 0, 0, 8'hFE);
        cyc("t4_armed",   1, 0, 0, 0, 0, 1, 3, S_ARMED, 0, 0, 0, 8'hFE);
        cyc("t4_start",   1, 0, 0, 1, 0, 1, 3, S_RUN,   0, 0, 0, 8'hFE);
        for (int k = 0; k < 2; k++) begin
            repeat (3) cyc("t4_hold_fe", 1, 0, 0, 0, 0, 1, 3, S_RUN, 0, 0, 0, 8'hFE);
            cyc("t4_tick_ff",            1, 0, 0, 0, 0, 1, 3, S_RUN, 0, 0, 0, 8'hFF);
            repeat (3) cyc("t4_hold_ff", 1, 0, 0, 0, 0, 1, 3, S_RUN, 0, 0, 0, 8'hFF);
            cyc("t4_tc_reload",          1, 0, 0, 0, 0, 1, 3, S_RUN, 0, 0, 1, 8'hFE);
        end

        // Stop beats start in RUN; count freezes.
        cyc("t5_stop_run", 1, 0, 0, 1, 1, 1, 3, S_IDLE,  0, 0, 0, 8'hFE);
        data1_pad = 8'hFF;
        cyc("t5_load1",    1, 0, 1, 0, 0, 0, 0, S_ARMED, 0, 1, 0, 8'hFF);
        cyc("t5_start",    1, 0, 0, 1, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFF);
        cyc("t5_tc_first", 1, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 1, 8'hFF);
        cyc("t5_restart",  1, 0, 0, 1, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFF);
        cyc("t5_tc_again", 1, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 1, 8'hFF);
        cyc("t5_done_stop",1, 0, 0, 1, 1, 0, 0, S_IDLE,  0, 0, 0, 8'hFF);
        cyc("t5_load1b",   1, 0, 1, 0, 0, 0, 0, S_ARMED, 0, 1, 0, 8'hFF);
        cyc("t5_start_b",  1, 0, 0, 1, 0, 0, 0, S_RUN,   0, 0, 0, 8'hFF);
        cyc("t5_tc_b",     1, 0, 0, 0, 0, 0, 0, S_DONE,  0, 0, 1, 8'hFF);
        data1_pad = 8'h33;
        cyc("t5_req_wins", 1, 0, 1, 1, 1, 0, 0, S_ARMED, 0, 1, 0, 8'h33);
        cyc("t5_armed",    1, 0, 0, 0, 0, 0, 0, S_ARMED, 0, 0, 0, 8'h33);

        // Reset mid-count restores the pointer to req0.
        cyc("t6_to_idle",  1, 0, 0, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'h33);
        data0_pad = 8'h80;
        data1_pad = 8'h44;
        cyc("t6_g1",       1, 1, 1, 0, 0, 0, 0, S_ARMED, 0, 1, 0, 8'h44);
        cyc("t6_stop",     1, 1, 1, 0, 1, 0, 0, S_IDLE,  0, 0, 0, 8'h44);
        cyc("t6_g0",       1, 1, 1, 0, 0, 0, 0, S_ARMED, 1, 0, 0, 8'h80);
        cyc("t6_run",      1, 0, 0, 1, 0, 0, 0, S_RUN,   0, 0, 0, 8'h80);
        cyc("t6_reset",    0, 0, 0, 1, 0, 0, 0, S_IDLE,  0, 0, 0, 8'h00);
        cyc("t6_ptr_req0", 1, 1, 1, 0, 0, 0, 0, S_ARMED, 1, 0, 0, 8'h80);
        cyc("t6_armed",    1, 0, 0, 0, 0, 0, 0, S_ARMED, 0, 0, 0, 8'h80);

        for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk_pad);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
